io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
Output-port consumer for the CPU's memory-mapped IO store (store to address 0xFF). It captures each single-cycle io_write/io_data pulse into a small FIFO. It then serialises each 64-bit word as 8 UART 8N1 bytes on txd, least-significant byte first. It sits directly downstream of the core, on the same clk/rst domain, and drives the board serial pin.

Parameters:
CLK_DIV, 16, clk cycles per UART bit; legal range ≥2.
FIFO_DEPTH, 4, word entries in the ingress FIFO; must be a power of two, ≥2.

Ports:
clk  in  1  system clock.
rst  in  1  reset, synchronous, active-high.
io_write  in  1  one-cycle strobe from the core; valid word on io_data.
io_data  in  64  word to transmit; sampled only when io_write=1.
clr_overflow  in  1  clears the sticky overflow flag.
txd  out  1  UART serial output; idle high; registered.
busy  out  1  high when the FIFO is non-empty or a frame is in progress.
overflow  out  1  sticky flag: a write was dropped because the FIFO was full.
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: txd=1, busy=0, overflow=0, level=0, FIFO flushed, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame: txd=1 after the next edge, and no partial byte resumes.
- Ingress: at an edge with io_write=1:
  - If level<FIFO_DEPTH (registered value, before any same-cycle pop), the word is pushed.
  - If level==FIFO_DEPTH, the word is dropped and overflow←1. This holds even if a pop occurs in the same cycle.
- Overflow flag: clr_overflow=1 clears it at the edge. If a drop and clr_overflow coincide, set wins.
- Level: level updates at the edge, +1 for push, -1 for pop, unchanged for push+pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If level>0, pop the head into a 64-bit shift register, byte_idx←0, go to START.
  - START: txd=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles. bit_idx counts 0..7.
  - STOP: txd=1 for CLK_DIV cycles. Then:
    - if byte_idx<7: byte_idx+1, shift register >>8, go to START;
    - else go to IDLE.
- Byte order: byte0 = io_data[7:0] first, through byte7 = io_data[63:56].
- Latency: io_write sampled at edge N → pushed at N → popped at edge N+1 → txd=0 from edge N+1.
- Timing per word: 80·CLK_DIV cycles. Exactly one IDLE cycle separates consecutive words.
- busy = (state≠IDLE) | (level≠0), registered-equivalent (derived from registered state only).
- The baud counter runs only outside IDLE and is reset to 0 on every state/bit transition.
- Width rules: all counters are unsigned and never wrap past their terminal values. Level never exceeds FIFO_DEPTH.

Decomposition:
- Shared package io_pkg holds:
  - the UART state enum (IDLE/START/DATA/STOP);
  - IO_ADDR=8'hFF;
  - FRAME_BITS=10;
  - BYTES_PER_WORD=8.
- One sub-module: io_fifo, a synchronous FIFO of width 64 and depth FIFO_DEPTH, with push/pop/full/empty/level outputs and read data valid combinationally from the head.

Test Plan:
1. Idle after reset: hold rst for 2 cycles, release, run 200 cycles with no writes → txd=1, busy=0, level=0, overflow=0 throughout.
2. Single word, CLK_DIV=4, io_data=64'h00000000000000A5 → txd low from edge N+1; first byte decodes to 0xA5 (bits 1,0,1,0,0,1,0,1); then 7 frames of 0x00. busy falls exactly 320 cycles after txd first falls.
3. Back-to-back writes 64'h0807060504030201 then 64'h1817161514131211 on consecutive cycles → decoded stream 01..08,11..18 in order; level peaks at 1; exactly one idle-high cycle between the two words' frames.
4. Overflow, FIFO_DEPTH=4: 6 writes on consecutive cycles, words W0..W5 → level sequence 1,1,2,3,4; W5 dropped, overflow=1 after the 6th edge; only W0..W4 appear on txd.
5. Overflow clear: assert clr_overflow in the same cycle as a dropped write → overflow stays 1. Assert clr_overflow alone → overflow=0 after the next edge.
6. Reset mid-frame: assert rst during the DATA bits of byte 3 of a word, with 2 words queued → txd=1 and level=0 after the edge. No further start bits appear for 500 cycles after release.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped IO output port (UART transmitter).
package io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [7:0] IO_ADDR        = 8'hFF;
    localparam int         FRAME_BITS     = 10;
    localparam int         BYTES_PER_WORD = 8;

endpackage

// File: rtl/io_uart_tx_if.sv
// Core-to-IO-port store bus: write strobe, 64-bit data word and overflow clear.
interface io_uart_tx_if;
    logic        io_write;
    logic [63:0] io_data;
    logic        clr_overflow;

    modport master (output io_write, output io_data, output clr_overflow);
    modport slave  (input  io_write, input  io_data, input  clr_overflow);
endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO; head word is readable combinationally while non-empty.
module io_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/io_uart_tx.sv
// IO store port: queues 64-bit words and sends each as 8 UART 8N1 bytes, LSB byte first.
module io_uart_tx
    import io_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    io_uart_tx_if.slave                  bus,
    output logic                         txd,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  level
);
    localparam int             CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0]     LAST_BYTE = 3'(BYTES_PER_WORD - 1);

    uart_state_t   state_reg, state_next;
    logic [CW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic [2:0]    byte_reg, byte_next;
    logic [63:0]   shreg_reg, shreg_next;
    logic          txd_reg, txd_next;
    logic          overflow_reg, overflow_next;

    logic [63:0]   fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          drop;
    logic          pop;
    logic          baud_done;
    logic [7:0]    cur_byte;

    // Full is judged on the registered level, so a same-cycle pop never rescues a write.
    assign push = bus.io_write && !fifo_full;
    assign drop = bus.io_write && fifo_full;

    io_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (bus.io_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign baud_done = (baud_reg == BAUD_LAST);
    assign cur_byte  = shreg_next[7:0];

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        byte_next  = byte_reg;
        shreg_next = shreg_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_next = fifo_rd_data;
                    byte_next  = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        bit_next   = '0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (byte_reg != LAST_BYTE) begin
                        byte_next  = byte_reg + 1'b1;
                        shreg_next = {8'h00, shreg_reg[63:8]};
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // txd is registered from the next-state view so the line tracks the state with no lag.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = cur_byte[bit_next];
            default: txd_next = 1'b1;
        endcase
    end

    always_comb begin
        overflow_next = overflow_reg;
        if (drop)                  overflow_next = 1'b1;
        else if (bus.clr_overflow) overflow_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            byte_reg     <= '0;
            shreg_reg    <= '0;
            txd_reg      <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            byte_reg     <= byte_next;
            shreg_reg    <= shreg_next;
            txd_reg      <= txd_next;
            overflow_reg <= overflow_next;
        end
    end

    assign txd      = txd_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: queue/timing model checked every cycle plus a UART line decoder.
module tb_io_uart_tx;
    localparam int CD = 4;
    localparam int FD = 4;
    localparam int WORD_CYC = 80 * CD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txd;
    logic       busy;
    logic       overflow;
    logic [2:0] level;

    io_uart_tx_if bus ();

    io_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .txd      (txd),
        .busy     (busy),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model: word queue + transmit countdown ----------------
    logic [63:0] m_q[$];
    logic [63:0] m_word  = '0;
    int          m_rem   = 0;
    logic        m_ov    = 1'b0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        int  lvl;
        bit  do_pop;
        cyc++;
        if (rst) begin
            m_q.delete();
            m_rem   = 0;
            m_ov    = 1'b0;
            m_valid = 1'b1;
        end else begin
            lvl    = m_q.size();
            do_pop = (m_rem == 0) && (lvl > 0);
            if (do_pop) begin
                m_word = m_q.pop_front();
                m_rem  = WORD_CYC;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
            if (bus.io_write && lvl < FD) m_q.push_back(bus.io_data);
            if (bus.io_write && lvl == FD) m_ov = 1'b1;
            else if (bus.clr_overflow)     m_ov = 1'b0;
        end
    end

    // Expected line level from the position within the 80*CD-cycle word.
    function automatic logic exp_txd();
        int el, bp, fr, b;
        if (m_rem == 0) return 1'b1;
        el = WORD_CYC - m_rem;
        bp = el / CD;
        fr = bp / 10;
        b  = bp % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_word[fr*8 + b - 1];
    endfunction

    int peak_level = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            check("txd",      txd,      exp_txd());
            check("busy",     busy,     (m_rem != 0) || (m_q.size() != 0));
            check("level",    level,    m_q.size());
            check("overflow", overflow, m_ov);
            if (int'(level) > peak_level) peak_level = level;
        end
    end

    // ---------------- UART line decoder ----------------
    logic [7:0] dec_q[$];
    int         fall_q[$];
    bit         in_frame = 1'b0;
    int         dcnt     = 0;
    logic [7:0] dbyte    = '0;

    always @(negedge clk) begin
        if (!m_valid || rst) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (txd == 1'b0) begin
                in_frame = 1'b1;
                dcnt     = 0;
                fall_q.push_back(cyc);
            end
        end else begin
            dcnt++;
            for (int i = 0; i < 8; i++)
                if (dcnt == CD*(i+1) + CD/2) dbyte[i] = txd;
            if (dcnt == CD*9 + CD/2) begin
                check("stop_bit", txd, 1'b1);
                dec_q.push_back(dbyte);
                in_frame = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int bound, input string name);
        for (int i = 0; i < bound && busy; i++) tick();
        check(name, busy, 1'b0);
    endtask

    task automatic write_word(input logic [63:0] w, input logic clr);
        bus.io_write     = 1'b1;
        bus.io_data      = w;
        bus.clr_overflow = clr;
        tick();
        bus.io_write     = 1'b0;
        bus.clr_overflow = 1'b0;
    endtask

    logic [63:0] wt [6];
    logic [7:0]  exp_b;
    int          w_cyc, fall_cyc, f0, nf;
    int          lv_exp [6];

    initial begin
        wt = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h00FF00FF00FF00FF,
               64'h8000000000000001, 64'h5A5A5A5AA5A5A5A5, 64'hDEADBEEFCAFEF00D};
        lv_exp = '{1, 1, 2, 3, 4, 4};
        bus.io_write     = 1'b0;
        bus.io_data      = '0;
        bus.clr_overflow = 1'b0;

        // 1: idle after reset
        rst = 1'b1;
        tick(); tick();
        check("reset_txd", txd, 1'b1);
        check("reset_level", level, 3'd0);
        rst = 1'b0;
        repeat (200) tick();
        check("idle_busy", busy, 1'b0);
        check("idle_no_frames", fall_q.size(), 0);

        // 2: single word 0xA5
        dec_q.delete(); fall_q.delete();
        write_word(64'h00000000000000A5, 1'b0);
        w_cyc = cyc;
        wait_drain(1000, "t2_drain_timeout");
        fall_cyc = cyc;
        check("t2_frames", fall_q.size(), 8);
        if (fall_q.size() > 0) begin
            check("t2_first_fall", fall_q[0], w_cyc + 1);
            check("t2_busy_fall", fall_cyc - fall_q[0], 320);
        end
        check("t2_bytes", dec_q.size(), 8);
        for (int k = 0; k < dec_q.size() && k < 8; k++) begin
            exp_b = (k == 0) ? 8'hA5 : 8'h00;
            check($sformatf("t2_byte%0d", k), dec_q[k], exp_b);
        end

        // 3: back-to-back words
        repeat (3) tick();
        dec_q.delete(); fall_q.delete(); peak_level = 0;
        write_word(64'h0807060504030201, 1'b0);
        write_word(64'h1817161514131211, 1'b0);
        wait_drain(2000, "t3_drain_timeout");
        check("t3_bytes", dec_q.size(), 16);
        for (int k = 0; k < dec_q.size() && k < 16; k++) begin
            exp_b = (k < 8) ? 8'(k + 1) : 8'(8'h11 + k - 8);
            check($sformatf("t3_byte%0d", k), dec_q[k], exp_b);
        end
        check("t3_peak_level", peak_level, 1);
        if (fall_q.size() >= 9) check("t3_word_gap", fall_q[8] - fall_q[0], 321);

        // 4: overflow
        repeat (3) tick();
        dec_q.delete(); fall_q.delete();
        for (int i = 0; i < 6; i++) begin
            write_word(wt[i], 1'b0);
            check($sformatf("t4_level%0d", i), level, lv_exp[i]);
            check($sformatf("t4_ovf%0d", i), overflow, (i == 5));
        end
        wait_drain(3000, "t4_drain_timeout");
        check("t4_bytes", dec_q.size(), 40);
        for (int k = 0; k < dec_q.size() && k < 40; k++)
            check($sformatf("t4_byte%0d", k), dec_q[k], wt[k/8][(k%8)*8 +: 8]);

        // 5: overflow clear rules
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        check("t5_clr_alone_a", overflow, 1'b0);
        for (int i = 0; i < 5; i++) write_word(wt[i], 1'b0);
        check("t5_full_level", level, 3'd4);
        write_word(wt[5], 1'b1);
        check("t5_set_wins", overflow, 1'b1);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        check("t5_clr_alone_b", overflow, 1'b0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("t5_reset_level", level, 3'd0);

        // 6: reset during byte 3 data bits with 2 words queued
        dec_q.delete(); fall_q.delete();
        for (int i = 0; i < 3; i++) write_word(wt[i], 1'b0);
        check("t6_queued", level, 3'd2);
        f0 = (fall_q.size() > 0) ? fall_q[0] : cyc;
        for (int i = 0; i < 400 && cyc < f0 + 3*10*CD + 4*CD; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_txd_after_rst", txd, 1'b1);
        check("t6_level_after_rst", level, 3'd0);
        nf = fall_q.size();
        repeat (500) tick();
        check("t6_no_new_frames", fall_q.size(), nf);
        check("t6_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
